// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and iteration-counter sizing.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } state_t;

  localparam int MDU_WIDTH = 32;
  localparam int CNT_W     = $clog2(MDU_WIDTH) + 1;

  // Counter must hold the value WIDTH itself, hence one bit beyond log2.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// ID/EX-side bundle for the MDU: operands, op launch, MTHI/MTLO writes, and
// the HI/LO/busy/done results plus an FSM state tap for observation.
//
// Handshake: start is a request sampled only while the unit is idle (busy=0);
// there is no ready back-pressure beyond busy. While busy=1 the producer must
// hold start low; any start seen while busy is dropped. done pulses for one
// cycle in the same cycle hi/lo first show the new result and busy is low.
interface mdu_if #(parameter int WIDTH = 32);

  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               mthi;
  logic               mtlo;
  logic [WIDTH-1:0]   wdata;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               busy;
  logic               done;
  mdu_pkg::state_t    state;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  hi, lo, busy, done, state
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output hi, lo, busy, done, state
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, bit_in};
  assign diff    = shifted - {1'b0, divisor};

  // rem < divisor keeps shifted < 2*divisor, so the top bit of diff is a
  // clean borrow flag. With divisor=0 diff equals shifted either way.
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Optional build macro MDU_EARLY_TERM_EN: multiply stops once the remaining
// multiplier bits are zero and the product is realigned in FIXUP.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t state, next_state;
  logic   busy_d, done_d;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] acc;
  logic               neg_lo_q;
  logic               neg_hi_q;
  logic               is_div_q;
  logic               div0_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic               is_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   div_rem;
  logic               div_qbit;
  logic               mul_last;
  logic [2*WIDTH-1:0] prod_aligned, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_abs     = (is_signed && bus.a[WIDTH-1]) ? ('0 - bus.a) : bus.a;
  assign b_abs     = (is_signed && bus.b[WIDTH-1]) ? ('0 - bus.b) : bus.b;

  // Shift-add: add the multiplicand at the top half, then shift right.
  assign mul_addend = opb_q[0] ? opa_q : '0;
  assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (acc[2*WIDTH-1:WIDTH]),
    .divisor (opb_q),
    .bit_in  (acc[WIDTH-1]),
    .rem_out (div_rem),
    .q_bit   (div_qbit)
  );

`ifdef MDU_EARLY_TERM_EN
  assign mul_last     = (cnt == CW'(1)) || (opb_q[WIDTH-1:1] == '0);
  // Each skipped iteration leaves the product one bit too far left.
  assign prod_aligned = acc >> cnt;
`else
  assign mul_last     = (cnt == CW'(1));
  assign prod_aligned = acc;
`endif

  assign prod_fix = neg_lo_q ? ('0 - prod_aligned) : prod_aligned;
  assign quo_fix  = neg_lo_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

  // State register with registered busy/done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = bus.op[1] ? DIV : MUL;
      MUL:     if (mul_last) next_state = FIXUP;
      DIV:     if (cnt == CW'(1)) next_state = FIXUP;
      FIXUP:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (next_state != IDLE);
    done_d = (state == FIXUP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc      <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            opa_q    <= a_abs;
            opb_q    <= b_abs;
            neg_lo_q <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_hi_q <= is_signed & bus.a[WIDTH-1];
            is_div_q <= bus.op[1];
            div0_q   <= (bus.b == '0);
            cnt      <= CW'(WIDTH);
            acc      <= bus.op[1] ? {{WIDTH{1'b0}}, a_abs} : '0;
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        MUL: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          opb_q <= opb_q >> 1;
          cnt   <= cnt - CW'(1);
        end
        DIV: begin
          acc <= {div_rem, acc[WIDTH-2:0], div_qbit};
          cnt <= cnt - CW'(1);
        end
        FIXUP: begin
          if (is_div_q) begin
            // Sign-corrected remainder of x/0 is x itself.
            hi_q <= rem_fix;
            lo_q <= div0_q ? '1 : quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: hand-computed results, latency, hold of
// hi/lo while busy, MTHI/MTLO priority and mid-operation reset.
module tb_mdu_iterative;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();

  mdu_iterative #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   mdl_hi = '0;
  logic [W-1:0]   mdl_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected busy length of a multiply, given the magnitude of the multiplier.
  function automatic int mul_cycles(input logic [W-1:0] m);
    int n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
`ifdef MDU_EARLY_TERM_EN
    return n + 1;
`else
    return (n > 0) ? W + 1 : 0;
`endif
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
  endtask

  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic with_mthi, input logic [W-1:0] wd);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    bus.mthi = with_mthi; bus.wdata = wd;
    @(negedge clk);
    bus.start = 1'b0; bus.mthi = 1'b0;
  endtask

  // poke_kind: 0 none, 1 extra start, 2 mtlo write; applied at busy cycle poke_cyc.
  task automatic finish_op(input string tag, input int exp_cyc, input int poke_cyc, input int poke_kind);
    int cyc = 0;
    int early_done = 0;
    int hold_bad = 0;
    logic [2*W-1:0] e;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (bus.done !== 1'b0) early_done++;
      if (bus.hi !== mdl_hi || bus.lo !== mdl_lo) hold_bad++;
      if (cyc == poke_cyc && poke_kind == 1) begin
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd5; bus.b = 32'd5;
      end
      if (cyc == poke_cyc && poke_kind == 2) begin
        bus.mtlo = 1'b1; bus.wdata = 32'hDEADBEEF;
      end
      @(negedge clk);
      bus.start = 1'b0; bus.mtlo = 1'b0;
    end
    check({tag, ".busy_cycles"}, cyc, exp_cyc);
    check({tag, ".hold"}, hold_bad, 0);
    check({tag, ".done_while_busy"}, early_done, 0);
    check({tag, ".done"}, bus.done, 1);
    e = exp_q.pop_front();
    check({tag, ".hi"}, bus.hi, e[2*W-1:W]);
    check({tag, ".lo"}, bus.lo, e[W-1:0]);
    mdl_hi = e[2*W-1:W];
    mdl_lo = e[W-1:0];
    @(negedge clk);
    check({tag, ".done_pulse"}, bus.done, 0);
    check({tag, ".idle_after"}, bus.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset.hi", bus.hi, 0);
    check("reset.lo", bus.lo, 0);
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.state", bus.state, IDLE);
    rst = 1'b1;

    // -3 * 5 = -15
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
    launch(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, '0);
    finish_op("mult_neg", mul_cycles(32'd5), 0, 0);

    exp_q.push_back({32'hFFFFFFFE, 32'h00000001});
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0);
    finish_op("multu_max", mul_cycles(32'hFFFFFFFF), 0, 0);

    // -7 / 2 = -3 rem -1
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    launch(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, '0);
    finish_op("div_neg", W + 1, 0, 0);

    exp_q.push_back({32'h00000000, 32'h80000000});
    launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, '0);
    finish_op("div_ovf", W + 1, 0, 0);

    // Divide by zero, with a stray start at busy cycle 10.
    exp_q.push_back({32'h00000064, 32'hFFFFFFFF});
    launch(OP_DIVU, 32'd100, 32'd0, 1'b0, '0);
    finish_op("divu_zero", W + 1, 10, 1);

    // mtlo while busy must be dropped.
    exp_q.push_back({32'h00000000, 32'h00000006});
    launch(OP_MULTU, 32'd2, 32'd3, 1'b0, '0);
    finish_op("mtlo_busy", mul_cycles(32'd3), 2, 2);

    @(negedge clk);
    bus.mthi = 1'b1; bus.wdata = 32'h12345678;
    @(negedge clk);
    bus.mthi = 1'b0;
    check("mthi.hi", bus.hi, 32'h12345678);
    check("mthi.lo", bus.lo, mdl_lo);
    mdl_hi = 32'h12345678;

    // start with mthi: the op wins, hi never takes wdata.
    exp_q.push_back({32'h00000000, 32'h00000014});
    launch(OP_MULTU, 32'd4, 32'd5, 1'b1, 32'hAAAA5555);
    check("start_mthi.hi_early", bus.hi, 32'h12345678);
    finish_op("start_mthi", mul_cycles(32'd5), 0, 0);

    // Reset in the middle of MULT 7*9.
    launch(OP_MULT, 32'd7, 32'd9, 1'b0, '0);
    repeat (11) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.state", bus.state, IDLE);
    check("midrst.busy", bus.busy, 0);
    check("midrst.hi", bus.hi, 0);
    check("midrst.lo", bus.lo, 0);
    check("midrst.done", bus.done, 0);
    mdl_hi = '0;
    mdl_lo = '0;
    @(negedge clk);
    check("midrst.done_hold", bus.done, 0);
    rst = 1'b1;

    exp_q.push_back({32'h00000000, 32'd63});
    launch(OP_MULT, 32'd7, 32'd9, 1'b0, '0);
    finish_op("mult_rerun", mul_cycles(32'd9), 0, 0);

    exp_q.push_back({32'h00000000, 32'd21});
    launch(OP_MULTU, 32'd7, 32'd3, 1'b0, '0);
    finish_op("multu_small", mul_cycles(32'd3), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
